instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the single-cycle DataPath.
- Owns the PC register and the instruction-memory request handshake.
- Presents one buffered {pc, inst} pair per accepted fetch to the DataPath.
- Accepts branch/jump redirects back from the DataPath.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory handshake and buffers one {pc, inst} pair.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises fetch_fault.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT  = 2'd2
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic        r_inst_valid;
    logic        w_inst_valid_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_pc_plus4_next;
    logic [31:0] w_fetch_pc_inc;
    logic        w_req;
    logic        w_accept;
    logic        w_consume;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_fault;
    logic        w_fault_next;
`endif

    assign w_req          = (r_state == FETCH) && (!r_inst_valid || !stall) && !redirect_valid;
    assign w_accept       = w_req && imem_ready;
    assign w_consume      = r_inst_valid && !stall;
    assign w_fetch_pc_inc = r_fetch_pc + PC_STEP;

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign pc_plus4   = r_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = r_fault;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect beats accept, accept beats a bare consume; BOOT takes a redirect but never requests.
    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_inst_valid_next = r_inst_valid;
        w_inst_next       = r_inst;
        w_pc_next         = r_pc;
        w_pc_plus4_next   = r_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_fault_next      = r_fault;
`endif
        case (r_state)
            BOOT, FETCH: begin
                w_state_next = FETCH;
                if (redirect_valid) begin
                    w_fetch_pc_next   = redirect_pc;
                    w_inst_valid_next = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_state_next = HALT;
                        w_fault_next = 1'b1;
                    end
`endif
                end else if (w_accept) begin
                    w_inst_next       = imem_rdata;
                    w_pc_next         = r_fetch_pc;
                    w_pc_plus4_next   = w_fetch_pc_inc;
                    w_inst_valid_next = 1'b1;
                    w_fetch_pc_next   = w_fetch_pc_inc;
                end else if (w_consume) begin
                    w_inst_valid_next = 1'b0;
                end
            end
            default: begin
                w_inst_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_pc         <= 32'h0;
            r_pc_plus4   <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            r_fetch_pc   <= w_fetch_pc_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst       <= w_inst_next;
            r_pc         <= w_pc_next;
            r_pc_plus4   <= w_pc_plus4_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault      <= w_fault_next;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a randomized run
// against a behavioural fetch model. Build with FETCH_MISALIGN_TRAP_EN to cover the trap.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          mBoot;
    bit          mHalt;
    bit          mFault;
    logic [31:0] mFetchPc;
    bit          mValid;
    logic [31:0] mInst;
    logic [31:0] mPc;
    logic [31:0] mPcPlus4;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc),
        .pc_plus4       (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image: word i holds 32'h2000_0000 + i
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h2000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mBoot    = 1'b1;
        mHalt    = 1'b0;
        mFault   = 1'b0;
        mFetchPc = 32'h0000_0000;
        mValid   = 1'b0;
        mInst    = 32'h0;
        mPc      = 32'h0;
        mPcPlus4 = 32'h0;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0000_0000);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_pc_plus4", pc_plus4, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    endtask

    // One clock cycle: drive inputs, check the request side, clock, then check the buffer side.
    task automatic applyStimulus(input bit s, input bit r, input bit rv, input logic [31:0] rpc);
        bit expReq;
        stall          = s;
        imem_ready     = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        expReq = !mBoot && !mHalt && (!mValid || !s) && !rv;
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        checkOutput("imem_addr_pre", imem_addr, mFetchPc);
        @(posedge clock);
        if (mHalt) begin
            mValid = 1'b0;
        end else if (rv) begin
            mFetchPc = rpc;
            mValid   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc % 4 != 0) begin
                mHalt  = 1'b1;
                mFault = 1'b1;
            end
`endif
        end else if (expReq && r) begin
            mInst    = memWord(mFetchPc);
            mPc      = mFetchPc;
            mPcPlus4 = mFetchPc + 32'd4;
            mValid   = 1'b1;
            mFetchPc = mFetchPc + 32'd4;
        end else if (mValid && !s) begin
            mValid = 1'b0;
        end
        mBoot = 1'b0;
        #1;
        checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, mValid});
        checkOutput("inst", inst, mInst);
        checkOutput("pc", pc, mPc);
        checkOutput("pc_plus4", pc_plus4, mPcPlus4);
        checkOutput("imem_addr_post", imem_addr, mFetchPc);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("fetch_fault", {31'b0, fetch_fault}, {31'b0, mFault});
`endif
    endtask

    // Raise reset away from a clock edge, check outputs before any edge, hold two edges, release.
    task automatic asyncReset();
        reset = 1'b1;
        #1;
        checkResetValues();
        modelReset();
        @(posedge clock);
        @(posedge clock);
        #1;
        checkResetValues();
        reset = 1'b0;
    endtask

    initial begin
        stall          = 1'b0;
        imem_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        reset          = 1'b1;
        modelReset();
        @(posedge clock);
        @(posedge clock);
        #1;
        checkResetValues();
        reset = 1'b0;

        // Boot idle cycle, then one instruction per cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("first_pc", pc, 32'h0000_0000);
        checkOutput("first_inst", inst, 32'h2000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("second_pc", pc, 32'h0000_0004);
        checkOutput("second_pc_plus4", pc_plus4, 32'h0000_0008);
        checkOutput("second_inst", inst, 32'h2000_0001);

        // Stall with pc=4 buffered, then consume plus accept of addr 8 together
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_pc_frozen", pc, 32'h0000_0004);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("after_stall_pc", pc, 32'h0000_0008);

        // Redirect coincident with ready on addr 12: data dropped, next request at 0x40
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        checkOutput("redirect_drop_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("redirect_addr", imem_addr, 32'h0000_0040);

        // Memory wait at 0x40, then reset mid-wait
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        asyncReset();

        // Restart at RESET_PC, then a 3-cycle memory wait on addr 8
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("restart_pc", pc, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("wait_addr", imem_addr, 32'h0000_0008);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wait_done_pc", pc, 32'h0000_0008);

        // Address wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        checkOutput("wrap_fetch_addr", imem_addr, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit s;
            bit r;
            bit rv;
            logic [31:0] rpc;
            s   = ($urandom % 4) == 0;
            r   = ($urandom % 3) != 0;
            rv  = ($urandom % 12) == 0;
            rpc = $urandom & 32'hFFFF_FFFC;
            applyStimulus(s, r, rv, rpc);
        end

        // Redirect during BOOT is taken
        asyncReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        checkOutput("boot_redirect_addr", imem_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("boot_redirect_pc", pc, 32'h0000_0100);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts until reset
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0042);
        checkOutput("trap_fault", {31'b0, fetch_fault}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        end
        asyncReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("trap_resume_pc", pc, 32'h0000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
